rr_arb4: RTL and testbench
==========================

// Module: rr_arb4
// PURPOSE
//  Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
//  Drives the mux select plus a one-hot grant, and holds a grant while the owner keeps requesting.
//  Forces rotation after HOLD_MAX cycles whenever another requester is waiting.
//  Sits directly in front of mux4; sel connects to the mux sel input.
// PARAMETERS
//  HOLD_MAX  8  max consecutive cycles one owner keeps the grant while others wait; 0 = unlimited
//  CW        4  hold-counter width; must satisfy 2**CW > HOLD_MAX
// PORTS
//  clk      in   1   rising-edge clock, the only clock
//  rst_n    in   1   asynchronous active-low reset
//  req      in   4   request per source; bit i = source i = mux input s<i>
//  gnt      out  4   one-hot grant, registered; 4'b0000 when idle
//  gnt_vld  out  1   registered; 1 iff gnt != 0
//  sel      out  2   registered encoded index of the owner, drives mux4 sel
// BEHAVIOUR
//  Reset (async assert, sync-to-clk deassert by the system):
//   gnt=0, gnt_vld=0, sel=2'b00, pointer ptr=0, hold count=0, state IDLE.
//  States: IDLE (no owner), BUSY (owner o). All outputs are flops; no comb path req->gnt.
//  Pick function: first set bit of req scanning ptr, ptr+1, ... mod 4 (ptr has top priority).
//  IDLE: if req!=0 at edge -> BUSY, owner=pick(req), cnt=1. Latency req->gnt = 1 clk.
//  BUSY, each edge:
//   req[o]=1 and (HOLD_MAX==0 or cnt<HOLD_MAX or no other req): keep o, cnt=sat(cnt+1).
//   req[o]=1, cnt>=HOLD_MAX, other req pending: preempt; ptr=o+1; owner=pick(req & ~onehot(o)); cnt=1.
//   req[o]=0: release; ptr=o+1; if other req -> new owner same edge (no idle bubble), cnt=1;
//     else -> IDLE, gnt=0, sel holds its last value.
//  ptr wraps 3->0. ptr changes only on release/preempt, never while idle.
//  sel always equals the index of the set gnt bit while gnt_vld=1; gnt never has >1 bit set.
//  Requesters must hold req until granted; dropping req before grant is allowed (request withdrawn).
//  Single requester never preempted regardless of cnt; cnt saturates at 2**CW-1.
//  Reset mid-grant: gnt drops asynchronously; after release, the first grant favours source 0.
// STRUCTURE
//  Shared package: N_SRC=4, SEL_W=2, state encodings ST_IDLE/ST_BUSY, onehot<->index functions.
//  One sub-module: rr_pick4 (combinational: req[3:0], ptr[1:0] -> any, idx[1:0]).
//  Top holds the state flop, owner/ptr/cnt registers and output flops.
// TESTING
//  1 reset, req=0 for 5 clk -> gnt=0, gnt_vld=0, sel=0 throughout.
//  2 ptr=0, req=4'b1010 at cycle 0 -> cycle 1 gnt=0010, sel=1; drop req[1] -> next clk gnt=1000, sel=3.
//  3 req=1111 held, HOLD_MAX=8 -> owners 0,1,2,3,0 each for exactly 8 clk, no idle cycle between.
//  4 req=0100 alone for 20 clk -> gnt=0100 for all 20, never preempted; release -> IDLE next clk.
//  5 owner=3, release with req=0001 -> gnt=0001 (wrap), sel=0, ptr becomes 0 then 1 on its release.
//  6 rst_n low mid-grant (async, between edges) -> gnt=0 immediately; after release req=1100 -> gnt=0100.
//  Assertions: $onehot0(gnt); gnt_vld==|gnt; gnt_vld -> gnt[sel]; no grant to a source with req=0 at the prior edge.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared definitions for the four-source round-robin arbiter: sizes, state
// encodings and one-hot/index conversion helpers.
package rr_arb4_pkg;

   localparam int N_SRC = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [N_SRC-1:0] idx2oh(input logic [SEL_W-1:0] idx);
      logic [N_SRC-1:0] oh;
      oh      = 4'b0000;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   function automatic logic [SEL_W-1:0] oh2idx(input logic [N_SRC-1:0] oh);
      logic [SEL_W-1:0] idx;
      case (oh)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/rr_arb4_pick.sv
// Rotating priority picker: first set request bit scanning from ptr upward,
// wrapping 3 -> 0. Purely combinational.
module rr_pick4
   import rr_arb4_pkg::*;
(
   input  logic [N_SRC-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] cand_s;

   // Scan from the farthest offset down so the nearest set bit wins last.
   always_comb begin
      any    = |req;
      idx    = ptr;
      cand_s = ptr;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         cand_s = ptr + SEL_W'(k);
         if (req[cand_s]) begin
            idx = cand_s;
         end else begin
            idx = idx;
         end
      end
   end

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter in front of a 4:1 mux: registered one-hot grant and mux
// select, grant held while the owner requests, forced rotation after HOLD_MAX.
module rr_arb4
   import rr_arb4_pkg::*;
#(
   parameter int HOLD_MAX = 8,
   parameter int CW       = 4
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       gnt_vld,
   output logic [1:0] sel
);

   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   state_t           state_r, state_s;
   logic [SEL_W-1:0] owner_r, owner_s;
   logic [SEL_W-1:0] ptr_r, ptr_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [N_SRC-1:0] gnt_r, gnt_s;
   logic             vld_r, vld_s;

   logic [N_SRC-1:0] own_oh_s;
   logic [N_SRC-1:0] others_s;
   logic             limit_s;
   logic [N_SRC-1:0] pick_req_s;
   logic [SEL_W-1:0] pick_ptr_s;
   logic             pick_any_s;
   logic [SEL_W-1:0] pick_idx_s;

   assign own_oh_s = idx2oh(owner_r);
   assign others_s = req & ~own_oh_s;
   assign limit_s  = (HOLD_MAX != 0) && (cnt_r >= HOLD_LIM);

   // While busy the picker only ever chooses among the other sources, starting after the owner.
   always_comb begin
      if (state_r == ST_BUSY) begin
         pick_req_s = others_s;
         pick_ptr_s = owner_r + 2'd1;
      end else begin
         pick_req_s = req;
         pick_ptr_s = ptr_r;
      end
   end

   rr_pick4 u_pick (
      .req (pick_req_s),
      .ptr (pick_ptr_s),
      .any (pick_any_s),
      .idx (pick_idx_s)
   );

   // Next-state and next-output computation.
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      ptr_s   = ptr_r;
      cnt_s   = cnt_r;
      gnt_s   = gnt_r;
      vld_s   = vld_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_any_s) begin
               state_s = ST_BUSY;
               owner_s = pick_idx_s;
               cnt_s   = CNT_ONE;
               gnt_s   = idx2oh(pick_idx_s);
               vld_s   = 1'b1;
            end else begin
               gnt_s   = 4'b0000;
               vld_s   = 1'b0;
            end
         end
         ST_BUSY: begin
            if (req[owner_r] && !(limit_s && (others_s != 4'b0000))) begin
               cnt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
               gnt_s = own_oh_s;
               vld_s = 1'b1;
            end else begin
               // Release or preempt: hand over on this edge when anyone else waits.
               ptr_s = owner_r + 2'd1;
               if (pick_any_s) begin
                  owner_s = pick_idx_s;
                  cnt_s   = CNT_ONE;
                  gnt_s   = idx2oh(pick_idx_s);
                  vld_s   = 1'b1;
               end else begin
                  state_s = ST_IDLE;
                  cnt_s   = {CW{1'b0}};
                  gnt_s   = 4'b0000;
                  vld_s   = 1'b0;
               end
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = {CW{1'b0}};
            gnt_s   = 4'b0000;
            vld_s   = 1'b0;
         end
      endcase
   end

   // State, arbitration registers and output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         owner_r <= 2'd0;
         ptr_r   <= 2'd0;
         cnt_r   <= {CW{1'b0}};
         gnt_r   <= 4'b0000;
         vld_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         ptr_r   <= ptr_s;
         cnt_r   <= cnt_s;
         gnt_r   <= gnt_s;
         vld_r   <= vld_s;
      end
   end

   assign gnt     = gnt_r;
   assign gnt_vld = vld_r;
   assign sel     = owner_r;

endmodule

// File: tb/tb_rr_arb4.sv
// Directed scoreboard bench for rr_arb4: each step pushes its expected grant,
// the output after the following clock edge is popped and compared.
module tb_rr_arb4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       gnt_vld;
   logic [1:0] sel;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] sel;
      string      tag;
   } exp_t;

   exp_t sb[$];

   rr_arb4 #(.HOLD_MAX(8), .CW(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_vld (gnt_vld),
      .sel     (sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish (observed=timeout required=finish)");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pop one expected result and compare it plus the grant invariants.
   task automatic check_out(input logic [3:0] r);
      exp_t e;
      logic [3:0] no_req;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_gnt"}, {4'h0, gnt}, {4'h0, e.gnt});
         chk({e.tag, "_vld"}, {7'h00, gnt_vld}, {7'h00, (e.gnt != 4'b0000)});
         chk({e.tag, "_sel"}, {6'h00, sel}, {6'h00, e.sel});
         chk({e.tag, "_onehot0"}, {7'h00, $onehot0(gnt)}, 8'h01);
         chk({e.tag, "_vld_or"}, {7'h00, gnt_vld}, {7'h00, |gnt});
         chk({e.tag, "_gnt_sel"}, {7'h00, (!gnt_vld || gnt[sel])}, 8'h01);
         no_req = gnt & ~r;
         chk({e.tag, "_req_held"}, {4'h0, no_req}, 8'h00);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es,
                       input string tag);
      exp_t e;
      req   = r;
      e.gnt = eg;
      e.sel = es;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out(r);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      #12;
      chk("rst_gnt", {4'h0, gnt}, 8'h00);
      chk("rst_vld", {7'h00, gnt_vld}, 8'h00);
      chk("rst_sel", {6'h00, sel}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: idle after reset
      for (int i = 0; i < 5; i++) step(4'b0000, 4'b0000, 2'd0, "idle");

      // 2: ptr=0 picks source 1, release hands to source 3 with no bubble
      step(4'b1010, 4'b0010, 2'd1, "t2_first");
      step(4'b1000, 4'b1000, 2'd3, "t2_handoff");
      step(4'b0000, 4'b0000, 2'd3, "t2_idle_sel_hold");

      // 3: all requesting, 8-cycle rotation 0,1,2,3,0
      for (int k = 0; k < 40; k++) begin
         step(4'b1111, 4'b0001 << ((k / 8) % 4), 2'((k / 8) % 4), $sformatf("t3_rot%0d", k));
      end
      step(4'b0000, 4'b0000, 2'd0, "t3_release");

      // 4: lone requester never preempted
      for (int k = 0; k < 20; k++) step(4'b0100, 4'b0100, 2'd2, $sformatf("t4_hold%0d", k));
      step(4'b0000, 4'b0000, 2'd2, "t4_release");

      // 5: owner 3 release wraps to source 0, then ptr moves to 1
      step(4'b1001, 4'b1000, 2'd3, "t5_owner3");
      step(4'b0001, 4'b0001, 2'd0, "t5_wrap");
      step(4'b0001, 4'b0001, 2'd0, "t5_keep0");
      step(4'b1100, 4'b0100, 2'd2, "t5_ptr1");
      step(4'b0000, 4'b0000, 2'd2, "t5_idle");

      // 6: asynchronous reset mid-grant
      step(4'b1000, 4'b1000, 2'd3, "t6_owner3");
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_async_gnt", {4'h0, gnt}, 8'h00);
      chk("t6_async_vld", {7'h00, gnt_vld}, 8'h00);
      chk("t6_async_sel", {6'h00, sel}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1100, 4'b0100, 2'd2, "t6_after_rst");
      step(4'b0000, 4'b0000, 2'd2, "t6_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
